coil_current_ctrl: RTL and testbench

Hysteretic peak/valley PWM controller for the output buck stage. It consumes the 48 MHz coil-current estimate produced by the coil model and generates the PWM signal that drives the switch and also feeds back into that model. The block enforces minimum on/off times, a maximum on-time, a soft-start ramp of the peak setpoint, and a latched over-current trip.

---
 rtl/coil_current_ctrl.sv | 149 ++++++++++++++
 tb/tb_coil_current_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coil_current_ctrl.sv
// -----------------------------------------------------------------------------
// coil_current_ctrl
//
// Hysteretic peak/valley PWM controller for the output buck stage. Compares the
// coil-current estimate against a soft-started peak setpoint and a valley
// (peak minus hysteresis). It enforces minimum on/off times and a maximum
// on-time, and latches an over-current trip.
//
// Ports:
//   clk          48 MHz system clock
//   reset        synchronous, active-high reset
//   enable       run request (level)
//   iest_coil    coil-current estimate, ADC native format (12 bit)
//   i_peak       target peak current, unsigned DN (205 DN/A)
//   i_hyst       peak-to-valley hysteresis, unsigned DN
//   pwm          switch drive, registered, high only in ON
//   active       high in ON or OFF
//   fault        latched over-current trip
//   ton_timeout  sticky: an on-pulse was ended by MAX_ON
//   pulse_cnt    number of on-pulses, saturating
// -----------------------------------------------------------------------------
module coil_current_ctrl #(
    parameter int MIN_ON   = 24,
    parameter int MIN_OFF  = 24,
    parameter int MAX_ON   = 480,
    parameter int RAMP_DIV = 48,
    parameter int I_LIMIT  = 1845
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] iest_coil,
    input  logic [10:0] i_peak,
    input  logic [9:0]  i_hyst,
    output logic        pwm,
    output logic        active,
    output logic        fault,
    output logic        ton_timeout,
    output logic [15:0] pulse_cnt
);

    typedef enum logic [1:0] {IDLE, ON, OFF, FAULT} state_t;

    localparam int                 RW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RW-1:0]      RAMP_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [9:0]         TON_MIN_L  = 10'(MIN_ON - 1);
    localparam logic [9:0]         TOFF_MIN_L = 10'(MIN_OFF - 1);
    localparam logic [9:0]         TON_MAX_L  = 10'(MAX_ON - 1);
    localparam logic signed [12:0] LIMIT      = 13'(I_LIMIT);

    state_t        state;
    state_t        state_nxt;
    logic [10:0]   peak_eff;
    logic [10:0]   valley;
    logic [9:0]    ton_cnt;
    logic [9:0]    toff_cnt;
    logic [RW-1:0] ramp_cnt;

    // The ADC word is offset-binary with an inverted magnitude; flipping the
    // low 11 bits yields a two's-complement current, positive for positive
    // coil current. It is widened by one bit so unsigned thresholds can be
    // compared signed without wrapping, which keeps negative current below
    // every threshold.
    logic signed [11:0] i_cur;
    logic signed [12:0] i_ext;
    assign i_cur = $signed(iest_coil ^ 12'h7FF);
    assign i_ext = $signed({i_cur[11], i_cur});

    logic over_lim, at_peak, at_valley, max_on_hit;
    assign over_lim   = i_ext > LIMIT;
    assign at_peak    = i_ext >= $signed({2'b00, peak_eff});
    assign at_valley  = i_ext <= $signed({2'b00, valley});
    assign max_on_hit = (ton_cnt == TON_MAX_L);

    // Valley floors at zero rather than wrapping while the setpoint is small.
    assign valley = ({1'b0, i_hyst} >= peak_eff) ? 11'd0 : peak_eff - {1'b0, i_hyst};

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Transition priority: over-current, then disable, then per-state rules.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
        state_nxt = state;
        if (state != FAULT && over_lim) begin
            state_nxt = FAULT;
        end else if ((state == ON || state == OFF) && !enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state_nxt = ON;
                ON:      if (max_on_hit || (ton_cnt >= TON_MIN_L && at_peak)) state_nxt = OFF;
                OFF:     if (toff_cnt >= TOFF_MIN_L && at_valley) state_nxt = ON;
                FAULT:   if (!enable) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register: one cycle from input condition to pwm.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            pwm         <= 1'b0;
            active      <= 1'b0;
            fault       <= 1'b0;
            ton_timeout <= 1'b0;
            pulse_cnt   <= 16'd0;
            ton_cnt     <= 10'd0;
            toff_cnt    <= 10'd0;
            ramp_cnt    <= '0;
            peak_eff    <= 11'd0;
        end else begin
            state  <= state_nxt;
            pwm    <= (state_nxt == ON);
            active <= (state_nxt == ON) || (state_nxt == OFF);
            fault  <= (state_nxt == FAULT);

            // Counters read 0 in the first cycle of their state.
            ton_cnt  <= (state == ON  && state_nxt == ON)  ? sat_inc(ton_cnt)  : 10'd0;
            toff_cnt <= (state == OFF && state_nxt == OFF) ? sat_inc(toff_cnt) : 10'd0;

            if (state_nxt == ON && state != ON && pulse_cnt != 16'hFFFF)
                pulse_cnt <= pulse_cnt + 16'd1;

            if (state == ON && state_nxt == OFF && max_on_hit)
                ton_timeout <= 1'b1;
            else if (state == IDLE && state_nxt == ON)
                ton_timeout <= 1'b0;

            // Soft-start: zero outside ON/OFF; the entry edge from IDLE leaves
            // both at zero so the ramp counts whole cycles spent running.
            if (state_nxt == IDLE || state_nxt == FAULT) begin
                ramp_cnt <= '0;
                peak_eff <= 11'd0;
            end else if (state == ON || state == OFF) begin
                ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + 1'b1;
                if (i_peak < peak_eff)
                    peak_eff <= i_peak;
                else if (peak_eff < i_peak && ramp_cnt == RAMP_LAST)
                    peak_eff <= peak_eff + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_coil_current_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coil_current_ctrl
//
// Scoreboard bench: the stimulus pushes the expected output transitions
// (new pwm/fault/active levels, length of the segment just ended, pulse_cnt,
// ton_timeout) before driving the inputs that cause them; a monitor pops and
// compares on every change of {pwm, fault, active}, sampled on the falling edge.
// The coil current follows a directed profile with hand-computed timings.
// -----------------------------------------------------------------------------
module tb_coil_current_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] iest_coil;
    logic [10:0] i_peak;
    logic [9:0]  i_hyst;
    logic        pwm;
    logic        active;
    logic        fault;
    logic        ton_timeout;
    logic [15:0] pulse_cnt;

    coil_current_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .iest_coil   (iest_coil),
        .i_peak      (i_peak),
        .i_hyst      (i_hyst),
        .pwm         (pwm),
        .active      (active),
        .fault       (fault),
        .ton_timeout (ton_timeout),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic        pwm;
        logic        fault;
        logic        active;
        logic        tto;
        int          width;   // cycles of the segment just ended, -1 = don't care
        logic [15:0] pcnt;
    } ev_t;

    ev_t         exp_q[$];
    int          ev_id    = 0;
    logic [15:0] exp_pcnt = 16'd0;
    logic        exp_pwm  = 1'b0;
    bit          mon_go   = 1'b0;

    // Stimulus-side view used only to time the inputs.
    int  dn       = 0;
    bit  track    = 1'b0;
    bit  prev_pwm = 1'b0;
    int  on_cyc   = 0;
    int  rises    = 0;
    int  falls    = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic push(input logic p, input logic f, input logic a, input logic t, input int w);
        ev_t e;
        if (p && !exp_pwm) exp_pcnt = exp_pcnt + 16'd1;
        exp_pwm  = p;
        e.id     = ev_id;
        e.pwm    = p;
        e.fault  = f;
        e.active = a;
        e.tto    = t;
        e.width  = w;
        e.pcnt   = exp_pcnt;
        ev_id++;
        exp_q.push_back(e);
    endtask

    task automatic apply();
        iest_coil = 12'(dn) ^ 12'h7FF;
    endtask

    // Advance one cycle; inputs are updated 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pwm === 1'b1) on_cyc = prev_pwm ? on_cyc + 1 : 0;
        if (pwm === 1'b1 && !prev_pwm) rises++;
        if (pwm === 1'b0 && prev_pwm) falls++;
        prev_pwm = (pwm === 1'b1);
        if (track) dn = dn + (prev_pwm ? 2 : -2);
        apply();
    endtask

    task automatic wait_on(input int n, input int budget, input string nm);
        int k = 0;
        while (!(pwm === 1'b1 && on_cyc == n) && k < budget) begin
            tick();
            k++;
        end
        check(nm, 32'(pwm === 1'b1 && on_cyc == n), 32'd1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string nm);
        int k = 0;
        while (rises < target && k < budget) begin
            tick();
            k++;
        end
        check(nm, 32'(rises >= target), 32'd1);
    endtask

    task automatic wait_falls(input int target, input int budget, input string nm);
        int k = 0;
        while (falls < target && k < budget) begin
            tick();
            k++;
        end
        check(nm, 32'(falls >= target), 32'd1);
    endtask

    // Monitor: compare every change of the visible state against the scoreboard.
    initial begin
        logic [2:0] prev_o;
        logic [2:0] cur_o;
        int         seg;
        ev_t        e;
        wait (mon_go);
        @(negedge clk);
        prev_o = {pwm, fault, active};
        seg    = 1;
        forever begin
            @(negedge clk);
            cur_o = {pwm, fault, active};
            if (cur_o !== prev_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got pwm/fault/active=%b want no change", cur_o);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("ev%0d.pwm", e.id),    32'(pwm),         32'(e.pwm));
                    check($sformatf("ev%0d.fault", e.id),  32'(fault),       32'(e.fault));
                    check($sformatf("ev%0d.active", e.id), 32'(active),      32'(e.active));
                    check($sformatf("ev%0d.tto", e.id),    32'(ton_timeout), 32'(e.tto));
                    check($sformatf("ev%0d.pcnt", e.id),   32'(pulse_cnt),   32'(e.pcnt));
                    if (e.width >= 0)
                        check($sformatf("ev%0d.width", e.id), 32'(seg), 32'(e.width));
                end
                seg    = 1;
                prev_o = cur_o;
            end else begin
                seg++;
            end
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got no end of test want end before 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        i_peak = 11'd0;
        i_hyst = 10'd205;
        dn     = 0;
        apply();
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        mon_go = 1'b1;

        // Reset then idle: everything stays at zero.
        for (int k = 0; k < 4; k++) begin
            repeat (25) @(negedge clk);
            check($sformatf("idle%0d", k), 32'({pwm, active, fault, ton_timeout, pulse_cnt}), 32'd0);
        end

        // Minimum on/off time with peak_eff pinned at 0 (i_peak = 0, 0 A).
        push(1, 0, 1, 0, -1);
        push(0, 0, 1, 0, 24);
        push(1, 0, 1, 0, 24);
        push(0, 0, 1, 0, 24);
        push(1, 0, 1, 0, 24);
        push(0, 0, 0, 0, 11);            // enable drop mid-ON
        tick();
        rises  = 0;
        enable = 1'b1;
        wait_rises(3, 300, "wait_minon_pulses");
        wait_on(10, 100, "wait_minon_ton10");
        enable = 1'b0;
        tick();

        // Soft-start ramp to 410 at 0 A: first pulse hits peak_eff=0 at MIN_ON,
        // afterwards every pulse runs to MAX_ON until the ramp completes.
        i_peak = 11'd410;
        repeat (3) tick();
        push(1, 0, 1, 0, -1);
        push(0, 0, 1, 0, 24);
        for (int k = 2; k <= 40; k++) begin
            push(1, 0, 1, (k > 2), 24);
            push(0, 0, 1, 1, 480);
        end
        push(1, 0, 1, 1, 24);
        rises  = 0;
        enable = 1'b1;
        wait_rises(41, 21000, "wait_ramp_done");

        // Steady hysteresis: DN starts at 200 and slews +/-2 per cycle with pwm.
        push(0, 0, 1, 1, 106);
        push(1, 0, 1, 1, 103);
        push(0, 0, 1, 1, 103);
        push(1, 0, 1, 1, 103);
        push(0, 0, 1, 1, 103);
        track = 1'b1;
        dn    = 200;
        apply();
        falls = 0;
        wait_falls(3, 1000, "wait_hyst_pulses");

        // Maximum on-time: DN held at 100 below the 410 peak.
        track = 1'b0;
        dn    = 100;
        apply();
        push(1, 0, 1, 1, 24);
        push(0, 0, 1, 1, 480);
        push(1, 0, 1, 1, 24);
        push(0, 0, 0, 1, 11);            // enable drop mid-ON
        wait_falls(4, 1000, "wait_maxon_pulse");

        // Setpoint drop mid-ON, then disable mid-ON.
        wait_on(5, 100, "wait_drop_ton5");
        check("peak_eff_ramped", 32'(dut.peak_eff), 32'd410);
        i_peak = 11'd300;
        tick();
        check("peak_eff_dropped", 32'(dut.peak_eff), 32'd300);
        wait_on(10, 100, "wait_drop_ton10");
        enable = 1'b0;
        tick();

        // Over-current: 1845 DN is tolerated, 1846 DN at ton_cnt=5 trips.
        dn = 0;
        apply();
        repeat (3) tick();
        push(1, 0, 1, 0, -1);
        push(0, 1, 0, 0, 6);
        push(0, 0, 0, 0, -1);
        enable = 1'b1;
        wait_on(2, 100, "wait_oc_ton2");
        dn = 1845;
        apply();
        wait_on(5, 100, "wait_oc_ton5");
        dn = 1846;
        apply();
        tick();
        dn = 0;
        apply();
        repeat (20) tick();
        check("fault_held", 32'({fault, pwm, active}), 32'b100);
        enable = 1'b0;
        repeat (3) tick();

        // Over-current and enable fall together: FAULT first, IDLE one cycle later.
        push(1, 0, 1, 0, -1);
        push(0, 1, 0, 0, 6);
        push(0, 0, 0, 0, 1);
        enable = 1'b1;
        wait_on(5, 100, "wait_simul_ton5");
        dn     = 1846;
        enable = 1'b0;
        apply();
        tick();
        dn = 0;
        apply();
        repeat (3) tick();

        // Reset mid-pulse drops pwm and clears pulse_cnt on the next edge.
        push(1, 0, 1, 0, -1);
        exp_pcnt = 16'd0;
        push(0, 0, 0, 0, 4);
        enable = 1'b1;
        wait_on(3, 100, "wait_rst_ton3");
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("final_idle", 32'({pwm, active, fault, ton_timeout, pulse_cnt}), 32'd0);
        check("queue_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
